dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the pipelined RV32 core: accepts one load/store request at a time from the core's memory stage over a valid/ready handshake and returns a response after a fixed, parameterised latency. It is the slave end of the core's data-memory port and replaces the zero-latency behavioural array for latency-tolerance testing of the pipeline's stall logic. Word-organised storage with byte-enable writes; single outstanding transaction.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words stored; word index = req_addr[31:2].
- LATENCY, 2: cycles from request acceptance to rsp_valid; legal range 1..15.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, lane-aligned.
- req_be  in  4  byte enables for stores; ignored for loads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  load data (full word); 0 for stores and errors.
- rsp_err  out  1  access fault flag for this response.

## Operation
- States: IDLE, BUSY, RESP. Reset forces IDLE.
- IDLE: req_ready=1. On req_valid&req_ready capture we/addr/wdata/be; go to RESP if LATENCY=1, else BUSY with counter=LATENCY-2.
- BUSY: req_ready=0; counter decrements each cycle; at counter=0 go to RESP.
- Commit point: on the edge entering RESP the access is performed — store writes enabled bytes, load registers the word into rsp_rdata.
- RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_valid&rsp_ready; then IDLE. req_ready=0 in RESP (no back-to-back overlap).
- Fault: word index ≥ DEPTH_WORDS → rsp_err=1, no write, rsp_rdata=0.
- Stores: rsp_rdata=0; response acts as write acknowledge.
- Storage contents are not cleared by reset; content before first write is undefined.

## Timing
- Reset values: req_ready=1 (after reset deasserts; 0 while reset=0), rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
- Request accepted at edge k → rsp_valid=1 from edge k+LATENCY.
- Minimum request-to-request spacing: LATENCY+1 cycles (response accepted in same cycle it appears at best).
- rsp_ready held low: responder stays in RESP indefinitely; no output changes.
- req_valid while req_ready=0: ignored, no capture.
- Reset asserted mid-transaction: pending request dropped; a store not yet committed is never written; a store already committed (state RESP) remains in memory.
- Load following store to same word: sees the stored data (commit precedes next acceptance).

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: load/store with req_addr[1:0]≠0 → rsp_err=1, no write, rsp_rdata=0 (in addition to range fault).
- Not defined: req_addr[1:0] ignored; access goes to the containing word, rsp_err only for range faults.

## Test plan
- Reset low 5 cycles with req_valid=1 → rsp_valid=0, req_ready=0 throughout; after release req_ready=1, no spurious response.
- Store 0xDEADBEEF, be=4'hF, addr 0x10; then load 0x10 (LATENCY=2) → rsp_valid exactly 2 cycles after each acceptance, load rsp_rdata=0xDEADBEEF, rsp_err=0.
- Store 0x000000AA, be=4'b0001 to 0x10 → subsequent load returns 0xDEADBEAA.
- Hold rsp_ready=0 10 cycles with second req_valid pending → rsp_rdata stable, req_ready=0, second request accepted only after response handshake.
- Load addr 0x1000 with DEPTH_WORDS=1024 → rsp_err=1, rsp_rdata=0; load addr 0x12 → rsp_err=1 with DMEM_MISALIGN_TRAP_EN, else returns word at 0x10.
- Store 0x12345678 to 0x20, reset asserted during BUSY (LATENCY=4) → after reset, load 0x20 returns prior contents, not 0x12345678.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory slave for the RV32 core: one outstanding load/store, word storage with byte-enable writes.
// Latency: response valid LATENCY cycles after acceptance; the access commits on the edge entering RESP.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready. Optional DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_be,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept, w_commit;
    logic          w_acc_we;
    logic [31:0]   w_acc_addr, w_acc_wdata;
    logic [3:0]    w_acc_be;
    logic [AW-1:0] w_idx;
    logic          w_fault_range, w_fault_align, w_fault;
    logic          w_unused_addr_lsb;

    assign o_req_ready = (r_state == IDLE) & i_rst_n;
    assign w_accept    = i_req_valid & o_req_ready;

    // With LATENCY=1 the commit edge is the acceptance edge, so use the live request in IDLE.
    assign w_acc_we    = (r_state == IDLE) ? i_req_we    : r_we;
    assign w_acc_addr  = (r_state == IDLE) ? i_req_addr  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? i_req_wdata : r_wdata;
    assign w_acc_be    = (r_state == IDLE) ? i_req_be    : r_be;

    assign w_idx         = w_acc_addr[AW+1:2];
    assign w_fault_range = {2'b00, w_acc_addr[31:2]} >= 32'(DEPTH_WORDS);
`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_fault_align = |w_acc_addr[1:0];
`else
    assign w_fault_align = 1'b0;
`endif
    assign w_fault           = w_fault_range | w_fault_align;
    assign w_unused_addr_lsb = &{1'b0, w_acc_addr[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = 4'(LATENCY - 2);
                    end
                end
            end
            BUSY: begin
                if (r_cnt == 4'd0) w_state_nxt = RESP;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            RESP: begin
                if (i_rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_commit = (w_state_nxt == RESP) && (r_state != RESP) && i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= i_req_we;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_be    <= i_req_be;
            end
            if (w_commit) begin
                r_err   <= w_fault;
                r_rdata <= (w_acc_we || w_fault) ? 32'd0 : r_mem[w_idx];
            end else if ((r_state == RESP) && i_rsp_ready) begin
                r_err   <= 1'b0;
                r_rdata <= 32'd0;
            end
        end
    end

    // Storage is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_commit && w_acc_we && !w_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_be[b]) r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
            end
        end
    end

    assign o_rsp_valid = (r_state == RESP);
    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;
endmodule
